// File: rtl/machine_mode_types_1_12_pkg.sv
// Machine-mode CSR and trap types shared by the priv block.
// Holds the standard exception/interrupt cause codes, the trap sequencer
// state encoding and the mcause base code used by RISC-MGMT extensions.
package machine_mode_types_1_12_pkg;

  // RISC-MGMT extension 0 reports this mcause code; extension N uses base+N,
  // which keeps all extension causes inside the custom 24..31 range.
  localparam int RMGMT_CAUSE_BASE = 24;

  typedef enum logic [4:0] {
    EX_INSN_MAL    = 5'd0,
    EX_INSN_FAULT  = 5'd1,
    EX_ILLEGAL     = 5'd2,
    EX_BREAKPOINT  = 5'd3,
    EX_LOAD_MAL    = 5'd4,
    EX_LOAD_FAULT  = 5'd5,
    EX_STORE_MAL   = 5'd6,
    EX_STORE_FAULT = 5'd7,
    EX_ECALL_M     = 5'd11
  } exc_code_t;

  typedef enum logic [4:0] {
    INT_SOFT_M  = 5'd3,
    INT_TIMER_M = 5'd7,
    INT_EXT_M   = 5'd11
  } int_code_t;

  typedef enum logic [1:0] {
    TRAP_IDLE,
    TRAP_DRAIN,
    TRAP_COMMIT,
    TRAP_RET_DRAIN
  } trap_state_t;

endpackage

// File: rtl/prv_trap_prio.sv
// Combinational trap prioritiser.
// Turns the raw exception flags and the already-enabled interrupt pending
// lines into a single {valid, is_int, code} selection. Any exception beats
// any interrupt.
// Ports:
//   exception flags, ex_rmgmt/ex_rmgmt_cause  - exception sources
//   ext_pend, soft_pend, timer_pend           - enabled, pending interrupts
//   valid, is_int, code                       - selected trap
//   no_tval                                   - selected trap reports mtval=0
module prv_trap_prio
  import machine_mode_types_1_12_pkg::*;
#(
  parameter int CW               = 1,
  parameter int RMGMT_CAUSE_BASE = 24
) (
  input  logic          fault_insn,
  input  logic          mal_insn,
  input  logic          illegal_insn,
  input  logic          fault_l,
  input  logic          mal_l,
  input  logic          fault_s,
  input  logic          mal_s,
  input  logic          breakpoint,
  input  logic          env_m,
  input  logic          ex_rmgmt,
  input  logic [CW-1:0] ex_rmgmt_cause,
  input  logic          ext_pend,
  input  logic          soft_pend,
  input  logic          timer_pend,
  output logic          valid,
  output logic          is_int,
  output logic [4:0]    code,
  output logic          no_tval
);

  always_comb begin
    valid   = 1'b1;
    is_int  = 1'b0;
    code    = 5'd0;
    no_tval = 1'b0;
    if (breakpoint)        code = EX_BREAKPOINT;
    else if (fault_insn)   code = EX_INSN_FAULT;
    else if (illegal_insn) code = EX_ILLEGAL;
    else if (mal_insn)     code = EX_INSN_MAL;
    else if (env_m) begin
      code    = EX_ECALL_M;
      no_tval = 1'b1;
    end
    else if (mal_l)        code = EX_LOAD_MAL;
    else if (fault_l)      code = EX_LOAD_FAULT;
    else if (mal_s)        code = EX_STORE_MAL;
    else if (fault_s)      code = EX_STORE_FAULT;
    else if (ex_rmgmt) begin
      code    = 5'(RMGMT_CAUSE_BASE) + 5'(ex_rmgmt_cause);
      no_tval = 1'b1;
    end
    else if (ext_pend | soft_pend | timer_pend) begin
      // Interrupts never carry a trap value.
      is_int  = 1'b1;
      no_tval = 1'b1;
      if (ext_pend)       code = INT_EXT_M;
      else if (soft_pend) code = INT_SOFT_M;
      else                code = INT_TIMER_M;
    end
    else begin
      valid   = 1'b0;
    end
  end

endmodule

// File: rtl/prv_trap_ctrl.sv
// Trap sequencer for the priv block.
// Detects exceptions/interrupts (and MRET), holds a flush request to the
// hazard unit until the pipeline is drained, then issues one cycle of CSR
// write strobes and a fetch redirect.
// Ports:
//   CLK, nRST                 - clock, synchronous active-low reset
//   exception/interrupt flags - from hazard unit and interrupt lines
//   ret, pipe_clear           - MRET at commit, pipeline drained
//   epc, badaddr              - captured into mepc/mtval on detection
//   mtvec, mepc_r             - current CSR values for redirect targets
//   intr, insert_pc, priv_pc  - flush request and redirect to hazard unit
//   m*_wen, mcause, mepc_wdata, mtval, trap_push, ret_pop - CSR file updates
module prv_trap_ctrl
  import machine_mode_types_1_12_pkg::*;
#(
  parameter int NUM_EXT          = 1,
  parameter int RMGMT_CAUSE_BASE = machine_mode_types_1_12_pkg::RMGMT_CAUSE_BASE,
  localparam int CW              = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          fault_insn,
  input  logic          mal_insn,
  input  logic          illegal_insn,
  input  logic          fault_l,
  input  logic          mal_l,
  input  logic          fault_s,
  input  logic          mal_s,
  input  logic          breakpoint,
  input  logic          env_m,
  input  logic          ex_rmgmt,
  input  logic [CW-1:0] ex_rmgmt_cause,
  input  logic          ret,
  input  logic          pipe_clear,
  input  logic [31:0]   epc,
  input  logic [31:0]   badaddr,
  input  logic          timer_int,
  input  logic          soft_int,
  input  logic          ext_int,
  input  logic          mstatus_mie,
  input  logic          mie_mtie,
  input  logic          mie_msie,
  input  logic          mie_meie,
  input  logic [31:0]   mtvec,
  input  logic [31:0]   mepc_r,
  output logic          intr,
  output logic          insert_pc,
  output logic [31:0]   priv_pc,
  output logic          mcause_wen,
  output logic [31:0]   mcause,
  output logic          mepc_wen,
  output logic [31:0]   mepc_wdata,
  output logic          mtval_wen,
  output logic [31:0]   mtval,
  output logic          trap_push,
  output logic          ret_pop
);

  trap_state_t state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic        is_int_q, is_int_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] tval_q, tval_d;

  logic        trap_valid;
  logic        trap_is_int;
  logic [4:0]  trap_code;
  logic        trap_no_tval;
  logic [31:0] trap_base;

  prv_trap_prio #(
    .CW               (CW),
    .RMGMT_CAUSE_BASE (RMGMT_CAUSE_BASE)
  ) u_prio (
    .fault_insn     (fault_insn),
    .mal_insn       (mal_insn),
    .illegal_insn   (illegal_insn),
    .fault_l        (fault_l),
    .mal_l          (mal_l),
    .fault_s        (fault_s),
    .mal_s          (mal_s),
    .breakpoint     (breakpoint),
    .env_m          (env_m),
    .ex_rmgmt       (ex_rmgmt),
    .ex_rmgmt_cause (ex_rmgmt_cause),
    .ext_pend       (mstatus_mie & ext_int & mie_meie),
    .soft_pend      (mstatus_mie & soft_int & mie_msie),
    .timer_pend     (mstatus_mie & timer_int & mie_mtie),
    .valid          (trap_valid),
    .is_int         (trap_is_int),
    .code           (trap_code),
    .no_tval        (trap_no_tval)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= TRAP_IDLE;
      code_q   <= 5'd0;
      is_int_q <= 1'b0;
      epc_q    <= 32'd0;
      tval_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      is_int_q <= is_int_d;
      epc_q    <= epc_d;
      tval_q   <= tval_d;
    end
  end

  assign trap_base  = {mtvec[31:2], 2'b00};
  assign mcause     = {is_int_q, 26'd0, code_q};
  assign mepc_wdata = epc_q;
  assign mtval      = tval_q;

  // Outputs decode only the registered state plus pipe_clear, so exception
  // inputs never reach the hazard unit combinationally. For the same reason
  // an MRET whose pipe_clear arrives alongside a new trap completes first;
  // the trap is then taken from IDLE.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    is_int_d   = is_int_q;
    epc_d      = epc_q;
    tval_d     = tval_q;
    intr       = 1'b0;
    insert_pc  = 1'b0;
    priv_pc    = 32'd0;
    mcause_wen = 1'b0;
    mepc_wen   = 1'b0;
    mtval_wen  = 1'b0;
    trap_push  = 1'b0;
    ret_pop    = 1'b0;

    unique case (state_q)
      TRAP_IDLE: begin
        if (trap_valid) begin
          state_d = TRAP_DRAIN;
        end else if (ret) begin
          state_d = TRAP_RET_DRAIN;
        end
      end
      TRAP_DRAIN: begin
        intr = 1'b1;
        if (pipe_clear) state_d = TRAP_COMMIT;
      end
      TRAP_COMMIT: begin
        intr       = 1'b1;
        insert_pc  = 1'b1;
        mcause_wen = 1'b1;
        mepc_wen   = 1'b1;
        mtval_wen  = 1'b1;
        trap_push  = 1'b1;
        priv_pc    = (is_int_q && mtvec[1:0] == 2'b01)
                     ? trap_base + {25'd0, code_q, 2'b00} : trap_base;
        state_d    = TRAP_IDLE;
      end
      TRAP_RET_DRAIN: begin
        if (pipe_clear) begin
          insert_pc = 1'b1;
          ret_pop   = 1'b1;
          priv_pc   = {mepc_r[31:2], 2'b00};
          state_d   = TRAP_IDLE;
        end else if (trap_valid) begin
          state_d = TRAP_DRAIN;
        end
      end
      default: state_d = TRAP_IDLE;
    endcase

    // Capture happens only on the transition into DRAIN; afterwards the
    // latched cause/epc/tval stay frozen until the next trap.
    if (state_d == TRAP_DRAIN && state_q != TRAP_DRAIN) begin
      code_d   = trap_code;
      is_int_d = trap_is_int;
      epc_d    = epc;
      tval_d   = trap_no_tval ? 32'd0 : badaddr;
    end
  end

endmodule

// File: doc/prv_trap_ctrl.md
Name: prv_trap_ctrl

Overview:
Trap-sequencing stage inside the priv block, directly downstream of the hazard-side exception/interrupt signals. It prioritises pending exceptions and interrupts, holds the pipeline flush request until the pipeline is clear, then commits trap CSR updates and redirects fetch. It does the same for MRET. It produces the priv_pc, insert_pc and intr values returned to the hazard unit, plus write strobes for the machine CSR file.

Parameters:
NUM_EXT, 1, number of RISC-MGMT extensions; ex_rmgmt_cause width is $clog2(NUM_EXT) (minimum 1).
RMGMT_CAUSE_BASE, 24, mcause code for RISC-MGMT extension 0 (custom range 24..31).

Ports:
CLK  in  1  clock
nRST  in  1  synchronous active-low reset
fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s, breakpoint, env_m  in  1 each  exception flags from hazard unit
ex_rmgmt  in  1  RISC-MGMT extension exception
ex_rmgmt_cause  in  $clog2(NUM_EXT)  extension index
ret  in  1  MRET reached commit
pipe_clear  in  1  pipeline drained, no older instruction in flight
epc  in  32  PC of the faulting/committing instruction
badaddr  in  32  faulting address or instruction bits
timer_int, soft_int, ext_int  in  1 each  interrupt pending lines
mstatus_mie  in  1  global machine interrupt enable
mie_mtie, mie_msie, mie_meie  in  1 each  per-source enables
mtvec  in  32  trap vector CSR value
mepc_r  in  32  current mepc CSR value
intr  out  1  trap pending, hazard unit must flush
insert_pc  out  1  one-cycle fetch redirect strobe
priv_pc  out  32  redirect target
mcause_wen  out  1  write strobe for mcause
mcause  out  32  {interrupt_bit, 26'b0, code[4:0]}
mepc_wen  out  1  write strobe for mepc
mepc_wdata  out  32  epc captured at detection
mtval_wen  out  1  write strobe for mtval
mtval  out  32  captured badaddr; 0 for interrupts, ecall and RISC-MGMT
trap_push  out  1  mstatus update: MPIE<=MIE, MIE<=0, MPP<=M
ret_pop  out  1  mstatus update: MIE<=MPIE, MPIE<=1

Behaviour:
- FSM states: IDLE, DRAIN, COMMIT, RET_DRAIN. All registers update on posedge CLK.
- When nRST=0 at a clock edge: state<=IDLE; all outputs 0; captured cause/epc/tval <=0. Reset mid-sequence aborts the sequence with no CSR write.
- exc_any = OR of the nine exception flags and ex_rmgmt.
- int_any = mstatus_mie & ((ext_int&mie_meie)|(soft_int&mie_msie)|(timer_int&mie_mtie)).
- Exception priority, highest first: breakpoint(3), fault_insn(1), illegal_insn(2), mal_insn(0), env_m(11), mal_l(4), fault_l(5), mal_s(6), fault_s(7), ex_rmgmt(RMGMT_CAUSE_BASE+ex_rmgmt_cause).
- Interrupt priority, highest first: ext(11), soft(3), timer(7).
- When an exception and an interrupt are present in the same cycle, the exception wins. The interrupt stays pending and is re-evaluated after the sequence returns to IDLE.
- IDLE:
  - exc_any|int_any: latch cause, interrupt bit, epc and tval; go to DRAIN.
  - else ret: go to RET_DRAIN.
  - Trap detection beats ret in the same cycle.
- DRAIN: intr=1. Latched values are frozen; later inputs are ignored. Stay until pipe_clear=1, then go to COMMIT.
- COMMIT: exactly one cycle, then IDLE. In this cycle:
  - insert_pc=1; mcause_wen, mepc_wen, mtval_wen and trap_push all =1.
  - priv_pc = {mtvec[31:2],2'b00}, except when mtvec[1:0]==2'b01 and the trap is an interrupt: priv_pc = base + (code<<2), computed mod 2^32.
  - intr stays 1 this cycle and drops the following cycle.
- RET_DRAIN: wait for pipe_clear.
  - On pipe_clear: insert_pc=1, priv_pc={mepc_r[31:2],2'b00}, ret_pop=1, same cycle; return to IDLE.
  - If exc_any or int_any arrives while in RET_DRAIN: abandon the return, latch the trap, go to DRAIN.
- If pipe_clear is already 1 on the detection cycle, it is still one cycle later in DRAIN: minimum latency is detect→COMMIT = 2 cycles.
- Write strobes are never asserted outside COMMIT/RET completion; outputs are registered-state decodes with no combinational path from the exception inputs to the outputs.

Decomposition:
- Cause code enums (exception and interrupt), the FSM state typedef and RMGMT_CAUSE_BASE go in machine_mode_types_1_12_pkg alongside the existing CSR types.
- One sub-module: prv_trap_prio, purely combinational, turning the exception/interrupt vectors into {valid, is_int, code[4:0]}. The FSM and capture registers stay in prv_trap_ctrl.

Test Plan:
- illegal_insn=1, epc=0x200, badaddr=0xDEAD, mtvec=0x100, pipe_clear asserted 3 cycles later → intr high until COMMIT; COMMIT: priv_pc=0x100, mcause=2, mepc_wdata=0x200, mtval=0xDEAD, trap_push=1.
- timer_int=1, mie_mtie=1, mstatus_mie=1, mtvec=0x101 (vectored), pipe_clear=1 → priv_pc=0x11C, mcause=0x80000007, mtval=0.
- mal_l and timer_int in the same cycle → mcause=4 taken first; after return to IDLE, the timer trap is taken with mcause=0x80000007.
- ret=1, mepc_r=0x403, pipe_clear after 2 cycles → insert_pc with priv_pc=0x400, ret_pop=1, no CSR strobes.
- ext_int arrives during RET_DRAIN → ret abandoned, mcause=0x8000000B, no ret_pop.
- nRST=0 during DRAIN → next cycle all outputs 0 and state IDLE; no mcause_wen ever seen.
